eight_three_encoder_seq: RTL and testbench

- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Accepts an 8-bit request vector over a valid/ready handshake.
- Emits the 3-bit binary index of every set bit, one per output handshake, in priority order.
- Sits between request sources (interrupt lines, arbiter grants) and consumers that need binary indices, e.g. a downstream 3-to-8 decoder.

---
 rtl/eight_three_encoder_seq.sv | 124 ++++++++++++
 tb/tb_eight_three_encoder_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/eight_three_encoder_seq.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index of each set bit in priority order.
// Optional feature macro ENC_POPCOUNT_EN adds the bit_count and zero_req outputs.
module eight_three_encoder_seq #(
  parameter int HIGH_FIRST = 1,
  parameter int IN_W       = 8,
  parameter int CODE_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              En,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IN_W-1:0]   X,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [CODE_W-1:0] O,
  output logic              code_last,
  output logic              busy
`ifdef ENC_POPCOUNT_EN
  ,
  output logic [3:0]        bit_count,
  output logic              zero_req
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [IN_W-1:0]   pending_q, pending_d;
  logic              rst_done_q, rst_done_d;
  logic [CODE_W-1:0] idx;
  logic              one_left;
  logic              accept;

  // Priority pick: the last match written wins, so the scan direction sets the priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    idx = '0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < IN_W; i++)
        if (pending_q[i]) idx = i[CODE_W-1:0];
    end else begin
      for (int i = IN_W - 1; i >= 0; i--)
        if (pending_q[i]) idx = i[CODE_W-1:0];
    end
  end

  assign one_left   = (pending_q != '0) &&
                      ((pending_q & (pending_q - IN_W'(1))) == '0);
  assign busy       = (state_q == ST_EMIT);
  assign code_valid = busy;
  assign O          = idx;
  assign code_last  = busy && one_left;
  // req_ready stays low until the first edge after reset release.
  assign req_ready  = rst_done_q && !busy && En;
  assign accept     = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    rst_done_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept && (X != '0)) begin
          pending_d = X;
          state_d   = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (code_ready) begin
          pending_d[idx] = 1'b0;
          if (one_left) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      rst_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pending_q  <= pending_d;
      rst_done_q <= rst_done_d;
    end
  end

`ifdef ENC_POPCOUNT_EN
  logic [3:0] bit_count_q, bit_count_d;
  logic       zero_req_q, zero_req_d;
  logic [3:0] ones;

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < IN_W; i++)
      ones = ones + {3'b000, X[i]};
    bit_count_d = bit_count_q;
    zero_req_d  = 1'b0;
    if (accept && (state_q == ST_IDLE)) begin
      if (X != '0) bit_count_d = ones;
      else         zero_req_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_count_q <= 4'd0;
      zero_req_q  <= 1'b0;
    end else begin
      bit_count_q <= bit_count_d;
      zero_req_q  <= zero_req_d;
    end
  end

  assign bit_count = bit_count_q;
  assign zero_req  = zero_req_q;
`endif

endmodule

// File: tb/tb_eight_three_encoder_seq.sv
// Randomized self-checking bench for eight_three_encoder_seq; runs both scan orders side by side.
module tb_eight_three_encoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       En;
  logic       req_valid;
  logic [7:0] X;
  logic       code_ready;

  logic       req_ready_hi, code_valid_hi, code_last_hi, busy_hi;
  logic [2:0] o_hi;
  logic       req_ready_lo, code_valid_lo, code_last_lo, busy_lo;
  logic [2:0] o_lo;
`ifdef ENC_POPCOUNT_EN
  logic [3:0] bit_count_hi, bit_count_lo;
  logic       zero_req_hi, zero_req_lo;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  eight_three_encoder_seq #(.HIGH_FIRST(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .En(En), .req_valid(req_valid), .req_ready(req_ready_hi),
    .X(X), .code_valid(code_valid_hi), .code_ready(code_ready), .O(o_hi),
    .code_last(code_last_hi), .busy(busy_hi)
`ifdef ENC_POPCOUNT_EN
    , .bit_count(bit_count_hi), .zero_req(zero_req_hi)
`endif
  );

  eight_three_encoder_seq #(.HIGH_FIRST(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .En(En), .req_valid(req_valid), .req_ready(req_ready_lo),
    .X(X), .code_valid(code_valid_lo), .code_ready(code_ready), .O(o_lo),
    .code_last(code_last_lo), .busy(busy_lo)
`ifdef ENC_POPCOUNT_EN
    , .bit_count(bit_count_lo), .zero_req(zero_req_lo)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the expected code sequence is just the list of set bit positions in scan order.
  task automatic run_req(input logic [7:0] x, input int stall, input int ready_pct, input bit hold_valid);
    int         q_hi[$];
    int         q_lo[$];
    logic [7:0] recon;
    int         lasts;
    int         cyc;
    int         k;
    k = 0;
    for (int i = 7; i >= 0; i--) if (x[i]) q_hi.push_back(i);
    for (int i = 0; i < 8; i++)  if (x[i]) begin q_lo.push_back(i); k++; end

    cyc = 0;
    while (!req_ready_hi && cyc < 20) begin step(); cyc++; end
    check("req_ready_before", {req_ready_hi, req_ready_lo}, 2'b11);

    req_valid = 1'b1;
    X = x;
    step();
    req_valid = hold_valid;
    X = 8'($urandom);

    if (x == 8'h00) begin
      check("zero_no_valid", {code_valid_hi, code_valid_lo, busy_hi, busy_lo}, 4'b0000);
      check("zero_ready", {req_ready_hi, req_ready_lo}, 2'b11);
`ifdef ENC_POPCOUNT_EN
      check("zero_req_pulse", {zero_req_hi, zero_req_lo}, 2'b11);
      req_valid = 1'b0;
      step();
      check("zero_req_drop", {zero_req_hi, zero_req_lo}, 2'b00);
`endif
      req_valid = 1'b0;
      return;
    end

`ifdef ENC_POPCOUNT_EN
    check("bit_count_hi", bit_count_hi, k);
    check("bit_count_lo", bit_count_lo, k);
`endif

    recon = 8'h00;
    lasts = 0;
    cyc   = 0;
    while (q_hi.size() > 0 && cyc < 400) begin
      code_ready = (cyc < stall) ? 1'b0 : ($urandom_range(99) < ready_pct);
      check("valid_busy", {code_valid_hi, busy_hi, code_valid_lo, busy_lo}, 4'b1111);
      check("req_ready_emit", {req_ready_hi, req_ready_lo}, 2'b00);
      check("o_hi", o_hi, q_hi[0]);
      check("o_lo", o_lo, q_lo[0]);
      check("last_hi", code_last_hi, q_hi.size() == 1);
      check("last_lo", code_last_lo, q_lo.size() == 1);
      if (code_ready) begin
        recon = recon | (8'h01 << o_hi);
        if (code_last_hi) lasts++;
        void'(q_hi.pop_front());
        void'(q_lo.pop_front());
      end
      step();
      cyc++;
    end
    code_ready = 1'b0;
    req_valid  = 1'b0;
    check("emit_done", q_hi.size(), 0);
    check("decoder_recon", recon, x);
    check("one_last", lasts, 1);
    if (stall == 0 && ready_pct >= 100) check("latency", cyc, k);
    check("idle_after", {code_valid_hi, busy_hi, code_valid_lo, busy_lo}, 4'b0000);
    check("req_ready_after", {req_ready_hi, req_ready_lo}, {En, En});
  endtask

  initial begin
    rst_n      = 1'b0;
    En         = 1'b1;
    req_valid  = 1'b0;
    X          = 8'h00;
    code_ready = 1'b0;
    #3;
    check("rst_req_ready", {req_ready_hi, req_ready_lo}, 2'b00);
    check("rst_outputs", {code_valid_hi, busy_hi, code_last_hi, o_hi}, 6'd0);
`ifdef ENC_POPCOUNT_EN
    check("rst_popcount", {bit_count_hi, zero_req_hi}, 5'd0);
`endif
    #9 rst_n = 1'b1;
    step();
    check("post_rst_ready", {req_ready_hi, req_ready_lo}, 2'b11);

    // Directed orders, backpressure and single-bit cases.
    run_req(8'b1010_0101, 0, 100, 1'b0);
    run_req(8'h81, 5, 100, 1'b0);
    run_req(8'h40, 0, 100, 1'b0);
    run_req(8'hFF, 0, 100, 1'b1);
    run_req(8'h00, 0, 100, 1'b0);

    // En gating: a held request must not be taken while En is low.
    En = 1'b0;
    req_valid = 1'b1;
    X = 8'h10;
    #1;
    check("en_low_ready", {req_ready_hi, req_ready_lo}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_low_idle", {code_valid_hi, busy_hi, code_valid_lo, busy_lo}, 4'b0000);
    end
    req_valid = 1'b0;
    En = 1'b1;
    #1;
    check("en_high_ready", req_ready_hi, 1'b1);
    run_req(8'h10, 0, 100, 1'b0);

    // Reset in the middle of an emission.
    req_valid = 1'b1;
    X = 8'hFF;
    step();
    req_valid = 1'b0;
    code_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    code_ready = 1'b0;
    check("pre_rst_o", o_hi, 3'd4);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {code_valid_hi, busy_hi, code_last_hi, o_hi}, 6'd0);
    check("mid_rst_lo", {code_valid_lo, busy_lo, o_lo}, 5'd0);
    check("mid_rst_ready", {req_ready_hi, req_ready_lo}, 2'b00);
    #2 rst_n = 1'b1;
    step();
    check("rel_ready", {req_ready_hi, req_ready_lo}, 2'b11);
    check("rel_idle", {code_valid_hi, busy_hi, code_valid_lo, busy_lo}, 4'b0000);

    // Exhaustive sweep with random backpressure.
    for (int v = 0; v < 256; v++)
      run_req(v[7:0], $urandom_range(2), 60, (v % 5) == 0);

    for (int r = 0; r < 20; r++)
      run_req(8'($urandom), $urandom_range(4), $urandom_range(30, 100), r[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
